// File: rtl/axi_traffic_gen.sv
// rtl/axi_traffic_gen.sv - AXI burst traffic generator with deterministic write data and read-back checking
// Optional TRAFFIC_GEN_LFSR_PATTERN_EN selects an LFSR data pattern instead of the running counter.
module axi_traffic_gen #(
    parameter int unsigned           ADDR_WIDTH  = 27,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           BURST_LEN   = 8,
    parameter int unsigned           NUM_BURSTS  = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           ADDR_STRIDE = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  trig,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic                  wvalid,
    input  logic                  wready,
    output logic                  wlast,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  bvalid,
    output logic                  bready,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic                  rlast,
    input  logic [DATA_WIDTH-1:0] rdata
);
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_e;

    localparam logic [8:0] LAST_BEAT = 9'(BURST_LEN - 1);
    localparam logic [7:0] AXI_LEN   = 8'(BURST_LEN - 1);

`ifdef TRAFFIC_GEN_LFSR_PATTERN_EN
    localparam logic [31:0] PAT_SEED = 32'h1;

    // Fibonacci LFSR for x^32+x^22+x^2+x+1
    function automatic logic [31:0] pat_step(input logic [31:0] p);
        return {p[30:0], p[31] ^ p[21] ^ p[1] ^ p[0]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pat_data(input logic [31:0] p);
        logic [DATA_WIDTH-1:0] d;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            d[i] = p[i % 32];
        end
        return d;
    endfunction
`else
    localparam logic [31:0] PAT_SEED = 32'h0;

    function automatic logic [31:0] pat_step(input logic [31:0] p);
        return p + 32'd1;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pat_data(input logic [31:0] p);
        return DATA_WIDTH'(p);
    endfunction
`endif

    state_e                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [31:0]             burst_q, burst_d;
    logic [8:0]              beat_q, beat_d;
    logic [31:0]             pat_q, pat_d;
    logic [15:0]             err_q, err_d;

    logic [ADDR_WIDTH-1:0]   addr_cur;
    logic [DATA_WIDTH-1:0]   exp_data;
    logic                    beat_last;
    logic                    burst_last;
    logic                    rd_mismatch;

    assign addr_cur    = BASE_ADDR + ADDR_WIDTH'(burst_q * ADDR_STRIDE);
    assign exp_data    = pat_data(pat_q);
    assign beat_last   = (beat_q == LAST_BEAT);
    assign burst_last  = (burst_q == 32'(NUM_BURSTS - 1));
    // Read-only runs have no written reference, so only rlast framing is judged there
    assign rd_mismatch = ((mode_q == 2'b11) && (rdata != exp_data)) || (rlast != beat_last);

    // Outputs decode from registered state only, so everything is zero while held in reset
    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);
    assign err_cnt = err_q;
    assign awvalid = (state_q == S_AW);
    assign awaddr  = awvalid ? addr_cur : '0;
    assign awlen   = awvalid ? AXI_LEN : '0;
    assign wvalid  = (state_q == S_W);
    assign wdata   = wvalid ? exp_data : '0;
    assign wlast   = wvalid && beat_last;
    assign bready  = (state_q == S_B);
    assign arvalid = (state_q == S_AR);
    assign araddr  = arvalid ? addr_cur : '0;
    assign arlen   = arvalid ? AXI_LEN : '0;
    assign rready  = (state_q == S_R);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            burst_q <= '0;
            beat_q  <= '0;
            pat_q   <= PAT_SEED;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            pat_q   <= pat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        pat_d   = pat_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (trig && (mode != 2'b00)) begin
                    mode_d  = mode;
                    err_d   = '0;
                    burst_d = '0;
                    beat_d  = '0;
                    pat_d   = PAT_SEED;
                    state_d = mode[0] ? S_AW : S_AR;
                end
            end
            S_AW: begin
                if (awready) begin
                    beat_d  = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (wready) begin
                    pat_d = pat_step(pat_q);
                    if (beat_last) begin
                        state_d = S_B;
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            S_B: begin
                if (bvalid) begin
                    if (!burst_last) begin
                        burst_d = burst_q + 32'd1;
                        state_d = S_AW;
                    end else if (mode_q == 2'b11) begin
                        burst_d = '0;
                        pat_d   = PAT_SEED;
                        state_d = S_AR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_AR: begin
                if (arready) begin
                    beat_d  = '0;
                    state_d = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    if (rd_mismatch && (err_q != 16'hFFFF)) begin
                        err_d = err_q + 16'd1;
                    end
                    pat_d = pat_step(pat_q);
                    if (beat_last) begin
                        if (!burst_last) begin
                            burst_d = burst_q + 32'd1;
                            state_d = S_AR;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        beat_d = beat_q + 9'd1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_traffic_gen.sv
// tb/tb_axi_traffic_gen.sv - scoreboard bench for axi_traffic_gen with a reactive memory slave
module tb_axi_traffic_gen;
    localparam int AW = 27;
    localparam int DW = 32;
    localparam int BL = 8;
    localparam int NB = 4;
    localparam logic [AW-1:0] BASE = 27'h7FFFFC0;
    localparam int unsigned STRIDE = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic trig = 1'b0;
    logic [1:0] mode = 2'b00;
    logic busy, done;
    logic [15:0] err_cnt;
    logic awvalid, awready = 1'b0;
    logic [AW-1:0] awaddr;
    logic [7:0] awlen;
    logic wvalid, wready = 1'b0, wlast;
    logic [DW-1:0] wdata;
    logic bvalid = 1'b0, bready;
    logic arvalid, arready = 1'b0;
    logic [AW-1:0] araddr;
    logic [7:0] arlen;
    logic rvalid = 1'b0, rready, rlast = 1'b0;
    logic [DW-1:0] rdata = '0;

    axi_traffic_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .NUM_BURSTS(NB),
        .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rstn(rstn), .trig(trig), .mode(mode),
        .busy(busy), .done(done), .err_cnt(err_cnt),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [AW-1:0] exp_aw_q[$];
    logic [DW:0]   exp_w_q[$];
    logic [AW-1:0] exp_ar_q[$];
    logic [15:0]   exp_done_q[$];

    int max_stall = 0;
    int corrupt_burst = -1;
    int corrupt_beat = -1;
    bit drop_rlast = 1'b0;
    int rd_burst = 0;
    int done_seen = 0;

    logic [DW-1:0] mem [logic [AW-1:0]];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int rnd();
        return int'($urandom_range(max_stall, 0));
    endfunction

    function automatic logic [AW-1:0] burst_addr(input int b);
        longint a;
        a = (longint'(BASE) + longint'(b) * longint'(STRIDE)) % (longint'(1) << AW);
        return AW'(a);
    endfunction

    task automatic push_expect(input logic [1:0] m, input int err);
        if (m[0]) begin
            for (int b = 0; b < NB; b++) begin
                exp_aw_q.push_back(burst_addr(b));
                for (int k = 0; k < BL; k++)
                    exp_w_q.push_back({(k == BL - 1), DW'(b * BL + k)});
            end
        end
        if (m[1]) begin
            for (int b = 0; b < NB; b++) exp_ar_q.push_back(burst_addr(b));
        end
        exp_done_q.push_back(16'(err));
    endtask

    // Reactive slave plus monitor: inputs are chosen first, then handshakes that
    // will complete at the coming rising edge are scored.
    int cyc = 0, last_hs = 0;
    int aw_wait = -1, w_wait = -1, ar_wait = -1, b_wait = 0, r_wait = 0;
    bit b_pend = 0, r_pend = 0, aw_st = 0, w_st = 0, done_prev = 0;
    logic [AW-1:0] aw_prev, wr_addr, r_addr, key;
    logic [DW-1:0] w_prev;
    int wr_beat = 0, r_beat = 0;

    initial begin : slave_monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0;
                rvalid = 0; rlast = 0; rdata = '0;
                aw_wait = -1; w_wait = -1; ar_wait = -1;
                b_pend = 0; r_pend = 0; aw_st = 0; w_st = 0; done_prev = 0;
            end else begin
                if (awvalid) begin
                    if (aw_wait < 0) aw_wait = rnd();
                    awready = (aw_wait == 0);
                    if (aw_wait > 0) aw_wait--;
                end else awready = 0;
                if (wvalid) begin
                    if (w_wait < 0) w_wait = rnd();
                    wready = (w_wait == 0);
                    if (w_wait > 0) w_wait--;
                end else wready = 0;
                if (arvalid) begin
                    if (ar_wait < 0) ar_wait = rnd();
                    arready = (ar_wait == 0);
                    if (ar_wait > 0) ar_wait--;
                end else arready = 0;
                if (b_pend && b_wait == 0) bvalid = 1;
                else begin
                    bvalid = 0;
                    if (b_pend) b_wait--;
                end
                rvalid = 0; rlast = 0;
                if (r_pend) begin
                    if (r_wait == 0) begin
                        rvalid = 1;
                        key = AW'(r_addr + AW'(r_beat * (DW / 8)));
                        rdata = mem.exists(key) ? mem[key] : DW'($urandom);
                        if (rd_burst == corrupt_burst && r_beat == corrupt_beat) rdata = rdata ^ DW'(1);
                        rlast = (r_beat == BL - 1) && !drop_rlast;
                    end else r_wait--;
                end

                if (awvalid && aw_st) check("awaddr_stable", awaddr, aw_prev);
                aw_st = awvalid && !awready; aw_prev = awaddr;
                if (wvalid && w_st) check("wdata_stable", wdata, w_prev);
                w_st = wvalid && !wready; w_prev = wdata;

                if (awvalid && awready) begin
                    check("aw_busy", busy, 1);
                    check("awlen", awlen, BL - 1);
                    if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
                    else check("awaddr", awaddr, exp_aw_q.pop_front());
                    wr_addr = awaddr; wr_beat = 0; aw_wait = -1;
                end
                if (wvalid && wready) begin
                    if (exp_w_q.size() == 0) check("w_unexpected", 1, 0);
                    else begin
                        logic [DW:0] e;
                        e = exp_w_q.pop_front();
                        check("wdata", wdata, e[DW-1:0]);
                        check("wlast", wlast, e[DW]);
                    end
                    mem[AW'(wr_addr + AW'(wr_beat * (DW / 8)))] = wdata;
                    wr_beat++;
                    w_wait = -1;
                    if (wr_beat == BL) begin b_pend = 1; b_wait = rnd(); end
                end
                if (bvalid && bready) begin b_pend = 0; last_hs = cyc; end
                if (arvalid && arready) begin
                    check("ar_busy", busy, 1);
                    check("arlen", arlen, BL - 1);
                    if (exp_ar_q.size() == 0) check("ar_unexpected", 1, 0);
                    else check("araddr", araddr, exp_ar_q.pop_front());
                    r_addr = araddr; r_beat = 0; r_pend = 1; r_wait = rnd(); ar_wait = -1;
                end
                if (rvalid && rready) begin
                    r_beat++;
                    if (r_beat == BL) begin r_pend = 0; rd_burst++; last_hs = cyc; end
                    else r_wait = rnd();
                end
                if (done) begin
                    check("done_busy", busy, 0);
                    check("done_pulse", done_prev, 0);
                    check("done_latency", cyc, last_hs + 1);
                    if (exp_done_q.size() == 0) check("done_unexpected", 1, 0);
                    else check("err_cnt", err_cnt, exp_done_q.pop_front());
                    done_seen++;
                end
                done_prev = done;
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_valids"}, {awvalid, wvalid, arvalid, bready, rready, wlast}, 0);
        check({tag, "_addr"}, {awaddr, araddr}, 0);
        check({tag, "_len"}, {awlen, arlen}, 0);
        check({tag, "_wdata"}, wdata, 0);
    endtask

    task automatic pulse_trig(input logic [1:0] m);
        @(negedge clk); trig = 1; mode = m;
        @(negedge clk); trig = 0; mode = 2'b00;
    endtask

    task automatic run(input logic [1:0] m, input int stall, input int cb, input int cbeat,
                       input bit drop, input int err, input bit retrig);
        int prev;
        bit ok;
        max_stall = stall; corrupt_burst = cb; corrupt_beat = cbeat; drop_rlast = drop;
        rd_burst = 0;
        push_expect(m, err);
        prev = done_seen;
        pulse_trig(m);
        check("run_busy", busy, 1);
        if (retrig) begin
            repeat (10) @(negedge clk);
            pulse_trig(2'b01);
        end
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done_seen > prev) begin ok = 1; break; end
        end
        check("run_timeout", ok, 1);
        repeat (3) @(negedge clk);
        check("q_aw_empty", exp_aw_q.size(), 0);
        check("q_w_empty", exp_w_q.size(), 0);
        check("q_ar_empty", exp_ar_q.size(), 0);
        check("q_done_empty", exp_done_q.size(), 0);
        check("err_held", err_cnt, err);
        check("idle_busy", busy, 0);
    endtask

    initial begin : stimulus
        int prev;
        bit ok;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1;
        pulse_trig(2'b00);
        repeat (5) @(negedge clk);
        check("mode00_busy", busy, 0);
        check("mode00_valid", {awvalid, arvalid}, 0);

        run(2'b01, 0, -1, -1, 0, 0, 0);
        run(2'b11, 0, -1, -1, 0, 0, 1);
        run(2'b11, 0, 1, 3, 0, 1, 0);
        run(2'b11, 5, -1, -1, 0, 0, 0);
        run(2'b10, 3, 0, 2, 1, NB, 0);

        max_stall = 2; corrupt_burst = -1; corrupt_beat = -1; drop_rlast = 0; rd_burst = 0;
        push_expect(2'b11, 0);
        prev = done_seen;
        pulse_trig(2'b11);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wvalid && exp_w_q.size() <= NB * BL - 12) begin ok = 1; break; end
        end
        check("reach_w_phase", ok, 1);
        #2 rstn = 0;
        #1 check_zero("midrun_reset");
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_done_q.delete();
        repeat (2) @(negedge clk);
        check("abort_no_done", done_seen, prev);
        rstn = 1;
        run(2'b11, 1, -1, -1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
